// File: rtl/snes_input_arbiter.sv
// rtl/snes_input_arbiter.sv - grants the SNES recoder to the button board or PS/2 decoder with a forced release gap
// Optional feature: ARB_ROUND_ROBIN_EN (round-robin on simultaneous requests instead of button-board priority).
module snes_input_arbiter #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bb_value,
    input  logic [3:0] ps2_value,
    input  logic       ps2_valid,
    output logic [3:0] value_out,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_GRANT_BB  = 2'd1;
    localparam logic [1:0] S_GRANT_PS2 = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ps2_code_q, ps2_code_d;
    logic             last_served_q, last_served_d;
    logic [3:0]       value_out_q, value_out_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;

    logic bb_req;
    logic ps2_req;
    logic pick_ps2;

    always_comb begin
        bb_req  = (bb_value != 4'h0);
        ps2_req = (ps2_code_q != 4'h0);
`ifdef ARB_ROUND_ROBIN_EN
        // last_served_q = 1 means PS/2 had the previous grant, so the board goes next
        pick_ps2 = ps2_req && (!bb_req || !last_served_q);
`else
        pick_ps2 = ps2_req && !bb_req;
`endif
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_served_d = last_served_q;
        value_out_d   = 4'h0;
        grant_d       = 2'b00;
        // Arbitration below sees the old code; a new strobe takes effect next cycle
        ps2_code_d    = ps2_valid ? ps2_value : ps2_code_q;

        case (state_q)
            S_IDLE: begin
                if (pick_ps2) begin
                    state_d       = S_GRANT_PS2;
                    value_out_d   = ps2_code_q;
                    grant_d       = 2'b10;
                    last_served_d = 1'b1;
                end else if (bb_req) begin
                    state_d       = S_GRANT_BB;
                    value_out_d   = bb_value;
                    grant_d       = 2'b01;
                    last_served_d = 1'b0;
                end
            end
            S_GRANT_BB: begin
                if (bb_req) begin
                    value_out_d = bb_value;
                    grant_d     = 2'b01;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            S_GRANT_PS2: begin
                if (ps2_req) begin
                    value_out_d = ps2_code_q;
                    grant_d     = 2'b10;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ps2_code_q    <= 4'h0;
            last_served_q <= 1'b1;
            value_out_q   <= 4'h0;
            grant_q       <= 2'b00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ps2_code_q    <= ps2_code_d;
            last_served_q <= last_served_d;
            value_out_q   <= value_out_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
        end
    end

    assign value_out = value_out_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_snes_input_arbiter.sv
// tb/tb_snes_input_arbiter.sv - checks two arbiters (HOLD_CYCLES 16 and 1) against a cycle model
module tb_snes_input_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bb_value;
    logic [3:0] ps2_value;
    logic       ps2_valid;
    logic [3:0] vo0, vo1;
    logic [1:0] g0, g1;
    logic       b0, b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    snes_input_arbiter #(.HOLD_CYCLES(16)) dut_h16 (
        .clk(clk), .reset(reset), .bb_value(bb_value), .ps2_value(ps2_value),
        .ps2_valid(ps2_valid), .value_out(vo0), .grant(g0), .busy(b0)
    );

    snes_input_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .reset(reset), .bb_value(bb_value), .ps2_value(ps2_value),
        .ps2_valid(ps2_valid), .value_out(vo1), .grant(g1), .busy(b1)
    );

    // Reference model: owner 0 = idle, 1 = board, 2 = PS/2, 3 = releasing
    int         m_owner [2];
    int         m_rem   [2];
    logic [3:0] m_out   [2];
    bit         m_last  [2];
    logic [3:0] m_code;
    int         m_hold  [2] = '{16, 1};

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = 0;
            m_rem[d]   = 0;
            m_out[d]   = 4'h0;
            m_last[d]  = 1'b1;
        end
        m_code = 4'h0;
    endtask

    task automatic model_edge();
        bit rb, rp, take_ps2;
        for (int d = 0; d < 2; d++) begin
            rb = (bb_value != 0);
            rp = (m_code != 0);
            case (m_owner[d])
                0: begin
                    take_ps2 = rp && !rb;
`ifdef ARB_ROUND_ROBIN_EN
                    if (rb && rp) take_ps2 = (m_last[d] == 1'b0);
`endif
                    m_out[d] = 4'h0;
                    if (take_ps2) begin
                        m_owner[d] = 2; m_out[d] = m_code; m_last[d] = 1'b1;
                    end else if (rb) begin
                        m_owner[d] = 1; m_out[d] = bb_value; m_last[d] = 1'b0;
                    end
                end
                1, 2: begin
                    if ((m_owner[d] == 1 && !rb) || (m_owner[d] == 2 && !rp)) begin
                        m_owner[d] = 3; m_rem[d] = m_hold[d]; m_out[d] = 4'h0;
                    end else begin
                        m_out[d] = (m_owner[d] == 1) ? bb_value : m_code;
                    end
                end
                default: begin
                    m_rem[d]--;
                    m_out[d] = 4'h0;
                    if (m_rem[d] == 0) m_owner[d] = 0;
                end
            endcase
        end
        if (ps2_valid) m_code = ps2_value;
    endtask

    function automatic logic [1:0] m_grant(input int d);
        return (m_owner[d] == 1) ? 2'b01 : (m_owner[d] == 2) ? 2'b10 : 2'b00;
    endfunction

    task automatic check_all();
        check_eq("h16_value", 8'(vo0), 8'(m_out[0]));
        check_eq("h16_grant", 8'(g0),  8'(m_grant(0)));
        check_eq("h16_busy",  8'(b0),  8'(m_owner[0] != 0));
        check_eq("h1_value",  8'(vo1), 8'(m_out[1]));
        check_eq("h1_grant",  8'(g1),  8'(m_grant(1)));
        check_eq("h1_busy",   8'(b1),  8'(m_owner[1] != 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge: reset between edges, outputs must clear before any clock edge
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq("async_value", 8'({vo1, vo0}), 8'h00);
        check_eq("async_grant", 8'({g1, g0}), 8'h00);
        check_eq("async_busy", 8'({b1, b0}), 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [1:0] exp_rr [3];

    initial begin
        reset = 1'b1; bb_value = 4'h0; ps2_value = 4'h0; ps2_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;
        step();

        bb_value = 4'h3; step();
        check_eq("first_grant", 8'(g0), 8'h01);
        check_eq("first_value", 8'(vo0), 8'h03);
        bb_value = 4'h5; step();
        check_eq("passthru_value", 8'(vo0), 8'h05);
        bb_value = 4'h0;
        repeat (20) step();

        ps2_value = 4'h7; ps2_valid = 1'b1; step();
        ps2_valid = 1'b0; step();
        check_eq("ps2_grant", 8'(g0), 8'h02);
        check_eq("ps2_value", 8'(vo0), 8'h07);
        bb_value = 4'h2; repeat (3) step();
        check_eq("no_preempt", 8'(g0), 8'h02);
        ps2_value = 4'h0; ps2_valid = 1'b1; step();
        ps2_valid = 1'b0;
        repeat (20) step();
        check_eq("bb_after_hold", 8'(g0), 8'h01);
        check_eq("bb_after_hold_val", 8'(vo0), 8'h02);

        async_reset();
        step();
        check_eq("regrant_after_reset", 8'(g0), 8'h01);
        bb_value = 4'h0;
        repeat (20) step();

`ifdef ARB_ROUND_ROBIN_EN
        exp_rr = '{2'b01, 2'b10, 2'b01};
`else
        exp_rr = '{2'b01, 2'b01, 2'b01};
`endif
        async_reset();
        for (int k = 0; k < 3; k++) begin
            ps2_value = 4'h9; ps2_valid = 1'b1; step();
            ps2_valid = 1'b0; bb_value = 4'h4; step();
            check_eq("simul_grant_h16", 8'(g0), 8'(exp_rr[k]));
            check_eq("simul_grant_h1", 8'(g1), 8'(exp_rr[k]));
            bb_value = 4'h0; ps2_value = 4'h0; ps2_valid = 1'b1; step();
            ps2_valid = 1'b0;
            repeat (20) step();
        end

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0)
                bb_value = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ps2_valid = ($urandom_range(0, 5) == 0);
            ps2_value = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 199) == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/snes_input_arbiter.md
# snes_input_arbiter

Shares the single SNES recoder datapath between the two local input sources: the button-board decoder and the PS/2 keyboard decoder. Each source presents a 4-bit button code where 4'h0 means no button. The arbiter grants one source at a time, forwards that source's code to the recoder, and enforces a minimum released gap between grants so the console always sees a clean button release. It sits between the two decoders and the recoder, clocked by the same clock as the recoder.

## Interface
Parameters:
- HOLD_CYCLES, 16: number of cycles value_out is forced to 4'h0 after a grant ends; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- bb_value  input  4  button-board code; a nonzero value is a request (level).
- ps2_value  input  4  PS/2 decoder code; sampled only when ps2_valid is high.
- ps2_valid  input  1  one-cycle strobe from the PS/2 frame counter; loads ps2_value into ps2_code_q.
- value_out  output  4  registered code to the recoder button_in.
- grant  output  2  registered grant: 2'b01 = button board, 2'b10 = PS/2, 2'b00 = none.
- busy  output  1  registered; high in GRANT_BB, GRANT_PS2 and HOLD.

## Operation
- Internal ps2_code_q (4 bits) loads ps2_value on every cycle that ps2_valid is high, zero included. PS/2 request = ps2_code_q != 0. Button-board request = bb_value != 0.
- State machine has four states: IDLE, GRANT_BB, GRANT_PS2 and HOLD.
- IDLE:
  - Only the button board requesting -> GRANT_BB.
  - Only PS/2 requesting -> GRANT_PS2.
  - Both requesting -> priority rule (see Configuration).
  - Neither requesting -> stay in IDLE.
- GRANT_BB:
  - value_out <= bb_value every cycle, so code changes within the grant pass through.
  - bb_value == 0 -> HOLD.
  - PS/2 requests are ignored. There is no preemption.
- GRANT_PS2: same as GRANT_BB, using ps2_code_q.
- HOLD:
  - value_out = 4'h0 and grant = 2'b00.
  - The counter loads HOLD_CYCLES-1 on entry and decrements each cycle.
  - At count 0 -> IDLE. Requests are ignored during HOLD.
- Counter width is $clog2(HOLD_CYCLES+1). It never wraps; it is only decremented while nonzero.
- A last_served flag (1 = PS/2) updates on each entry to a GRANT state.
- Reset values:
  - Outputs: value_out = 4'h0, grant = 2'b00, busy = 0.
  - Internal: state = IDLE, counter = 0, ps2_code_q = 4'h0, last_served = 1.

## Timing
- Grant latency: a request present at rising edge n in IDLE gives grant and value_out valid after edge n+1 (one-cycle registered latency).
- In-grant code change: bb_value changes at edge n -> value_out updates after edge n+1.
- Release timing:
  - The granted source reads 0 at edge n -> HOLD is entered and value_out = 0 after edge n+1.
  - value_out stays 0 for exactly HOLD_CYCLES cycles, then IDLE for at least one cycle.
  - A new grant therefore appears no earlier than HOLD_CYCLES+2 cycles after the release edge.
- ps2_valid and an arbitration decision in the same cycle: the decision uses the old ps2_code_q. The new code takes effect one cycle later.
- Reset asserted mid-grant or mid-HOLD: all outputs go to their reset values immediately, without waiting for a clock edge. Operation resumes in IDLE on the first edge after deassertion.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: on a simultaneous request in IDLE, the source not equal to last_served wins. After reset, the button board wins first.
  - Undefined: the button board always wins simultaneous requests. last_served is still maintained but unused.

## Test plan
- Reset, then bb_value = 4'h3 -> after one edge, grant = 01 and value_out = 4'h3. bb_value = 4'h5 -> value_out = 4'h5 one cycle later.
- ps2_valid pulse with ps2_value = 4'h7 while idle -> grant = 10 and value_out = 4'h7. ps2_valid with 4'h0 -> HOLD, value_out = 0 for 16 cycles, then grant = 00 and busy = 0.
- In GRANT_PS2, bb_value = 4'h2 is held -> no change until PS/2 releases. After HOLD (16 cycles) plus one IDLE cycle, grant = 01 and value_out = 4'h2.
- Both sources request simultaneously from IDLE, repeated three times with a release between each:
  - Macro undefined -> grant is 01, 01, 01.
  - ARB_ROUND_ROBIN_EN defined -> grant is 01, 10, 01.
- Assert reset asynchronously mid-GRANT_BB between clock edges -> value_out = 0, grant = 00 and busy = 0 immediately. After release, with bb_value still nonzero, the grant returns one edge later.
- HOLD_CYCLES = 1: release of the granted source -> value_out = 0 for exactly one cycle, then IDLE for one cycle, then the next grant.
